// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - access codes, arbiter state and size helper for the data memory arbiter
package dmem_pkg;

  // Read codes (bit3 = 0); 0, 6 and 7 perform no access
  localparam logic [3:0] RW_NONE = 4'd0;
  localparam logic [3:0] RW_LB   = 4'd1;
  localparam logic [3:0] RW_LH   = 4'd2;
  localparam logic [3:0] RW_LW   = 4'd3;
  localparam logic [3:0] RW_LBU  = 4'd4;
  localparam logic [3:0] RW_LHU  = 4'd5;

  // Write codes (bit3 = 1)
  localparam logic [3:0] RW_SB   = 4'b1000;
  localparam logic [3:0] RW_SH   = 4'b1001;
  localparam logic [3:0] RW_SW   = 4'b1010;

  typedef enum logic [0:0] {
    ST_SHARED = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Number of bytes touched by an access code; 0 means no access at all
  function automatic logic [2:0] rw_nbytes(input logic [3:0] rw);
    logic [2:0] n;
    if (rw[3]) begin
      case (rw[2:0])
        3'd0:    n = 3'd1;
        3'd1:    n = 3'd2;
        default: n = 3'd4;
      endcase
    end else begin
      case (rw[2:0])
        3'd1, 3'd4: n = 3'd1;
        3'd2, 3'd5: n = 3'd2;
        3'd3:       n = 3'd4;
        default:    n = 3'd0;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/dmem_range_chk.sv
// rtl/dmem_range_chk.sv - combinational out-of-range detector for one memory port
module dmem_range_chk
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 65536
) (
  input  logic [3:0]  rw_i,
  input  logic [31:0] addr_i,
  output logic        fault_o
);

  logic [2:0]  nbytes;
  logic [32:0] end_addr;

  assign nbytes   = rw_nbytes(rw_i);
  // 33-bit sum so an address near 2^32 wraps into a fault instead of back into range
  assign end_addr = {1'b0, addr_i} + {30'd0, nbytes};
  assign fault_o  = (nbytes != 3'd0) && (end_addr > 33'(MEM_SIZE));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/loader arbiter and sequencer for the single-port data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 65536,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        rst_n,

  input  logic        cpu_valid,
  input  logic [3:0]  cpu_rw,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_fault,

  input  logic        ldr_valid,
  input  logic [3:0]  ldr_rw,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  input  logic        ldr_lock,
  output logic        ldr_ready,
  output logic        ldr_rsp_valid,
  output logic [31:0] ldr_rsp_data,
  output logic        ldr_rsp_err,

  output logic [3:0]  mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,

  output logic [31:0] fault_addr
);

  localparam int unsigned    WCW      = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  arb_state_e     state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]    fault_addr_q, fault_addr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic        cpu_oor, ldr_oor;
  logic        locked, starve;
  logic        gnt_cpu, gnt_ldr;
  logic [3:0]  sel_rw;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_fault;
  logic        ldr_is_read;

  dmem_range_chk #(.MEM_SIZE(MEM_SIZE)) u_cpu_chk (
    .rw_i    (cpu_rw),
    .addr_i  (cpu_addr),
    .fault_o (cpu_oor)
  );

  dmem_range_chk #(.MEM_SIZE(MEM_SIZE)) u_ldr_chk (
    .rw_i    (ldr_rw),
    .addr_i  (ldr_addr),
    .fault_o (ldr_oor)
  );

  // The lock only holds while ldr_lock stays high; the release cycle is arbitrated as shared
  assign locked      = (state_q == ST_LOCKED) && ldr_lock;
  assign starve      = (wait_cnt_q == WAIT_MAX);
  assign ldr_is_read = !ldr_rw[3] && (rw_nbytes(ldr_rw) != 3'd0);

  // Grant decision: CPU has priority unless the loader is starving or holds a burst lock
  always_comb begin
    gnt_ldr = 1'b0;
    gnt_cpu = 1'b0;
    if (locked) begin
      gnt_ldr = ldr_valid;
    end else begin
      gnt_ldr = ldr_valid && (!cpu_valid || starve);
      gnt_cpu = cpu_valid && !gnt_ldr;
    end
  end

  // Route the winning port to the memory; an out-of-range access is turned into no access
  always_comb begin
    sel_rw    = 4'd0;
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    sel_fault = 1'b0;
    if (gnt_cpu) begin
      sel_rw    = cpu_rw;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      sel_fault = cpu_oor;
    end else if (gnt_ldr) begin
      sel_rw    = ldr_rw;
      sel_addr  = ldr_addr;
      sel_wdata = ldr_wdata;
      sel_fault = ldr_oor;
    end
  end

  assign mem_rw    = sel_fault ? 4'd0 : sel_rw;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  assign cpu_ready = gnt_cpu;
  assign cpu_fault = gnt_cpu && cpu_oor;
  assign cpu_rdata = gnt_cpu ? mem_rdata : 32'd0;
  assign ldr_ready = gnt_ldr;

  // Next-state: lock transitions, loader starvation counter, sticky fault address, loader response
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_LOCKED) && !ldr_lock) begin
      state_d = ST_SHARED;
    end
    if (gnt_ldr && ldr_lock) begin
      state_d = ST_LOCKED;
    end

    wait_cnt_d = wait_cnt_q;
    if (gnt_ldr || !ldr_valid) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end

    fault_addr_d = fault_addr_q;
    if (sel_fault) begin
      fault_addr_d = sel_addr;
    end

    rsp_valid_d = gnt_ldr;
    rsp_err_d   = gnt_ldr && ldr_oor;
    rsp_data_d  = (gnt_ldr && !ldr_oor && ldr_is_read) ? mem_rdata : 32'd0;
  end

  // State registers; reset drops any lock and any pending loader response at once
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SHARED;
      wait_cnt_q   <= '0;
      fault_addr_q <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      fault_addr_q <= fault_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign ldr_rsp_valid = rsp_valid_q;
  assign ldr_rsp_data  = rsp_data_q;
  assign ldr_rsp_err   = rsp_err_q;
  assign fault_addr    = fault_addr_q;

endmodule
